// File: rtl/dds_spi_pkg.sv
// Shared definitions for the DDS SPI command master:
// command opcodes, FSM states and frame-length helpers.
package dds_spi_pkg;

    localparam logic [7:0] CMD_FREQ = 8'h01;
    localparam logic [7:0] CMD_ENV  = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // Bytes on the wire: opcode plus up to two payload bytes.
    function automatic logic [1:0] frame_bytes(input logic [1:0] nbytes);
        return (nbytes == 2'd3) ? 2'd3 : nbytes + 2'd1;
    endfunction

    // Index of the last bit, i.e. 8*N-1.
    function automatic logic [4:0] frame_last_bit(input logic [1:0] nbytes);
        return {frame_bytes(nbytes) - 2'd1, 3'b111};
    endfunction

endpackage

// File: rtl/dds_spi_cmd_master_sclk_div.sv
// SPI clock generator: mode-0 sclk with one-cycle rise/fall strobes,
// held low and restarted whenever the enable is low.
module spi_sclk_div
    import dds_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick,
    output logic spi_sclk
);

    localparam int W = $clog2(CLK_DIV) + 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap      = en && (cnt == LAST);
    assign rise_tick = wrap && !spi_sclk;
    assign fall_tick = wrap && spi_sclk;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt      <= '0;
            spi_sclk <= 1'b0;
        end else if (!en) begin
            cnt      <= '0;
            spi_sclk <= 1'b0;
        end else if (wrap) begin
            cnt      <= '0;
            spi_sclk <= !spi_sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dds_spi_cmd_master.sv
// SPI master that frames one DDS command (opcode + 0..2 bytes)
// per nss window in mode 0 and captures MISO for read-back.
module dds_spi_cmd_master
    import dds_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [15:0] cmd_data,
    input  logic [1:0]  cmd_nbytes,
    output logic        rsp_valid,
    output logic [23:0] rsp_data,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_nss,
    input  logic        spi_miso
);

    localparam int TMAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TMAX  = (TMAX0 > IDLE_GAP) ? TMAX0 : IDLE_GAP;
    localparam int TW    = $clog2(TMAX) + 1;

    state_t          state, state_nx;
    logic [TW-1:0]   tmr, tmr_load;
    logic [4:0]      bit_cnt, last_bit;
    logic [23:0]     tx, rx;
    logic            accept, tmr_done, entering;
    logic            rise_tick, fall_tick;

    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign tmr_done  = (tmr == '0);
    assign entering  = (state_nx != state);

    spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .nreset    (nreset),
        .en        (state == SHIFT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .spi_sclk  (spi_sclk)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        spi_nss  = 1'b1;
        spi_mosi = 1'b0;
        tmr_load = '0;
        unique case (state)
            IDLE:  if (accept) state_nx = SETUP;
            SETUP: if (tmr_done) state_nx = SHIFT;
            SHIFT: if (fall_tick && bit_cnt == 5'd0) state_nx = HOLD;
            HOLD:  if (tmr_done) state_nx = GAP;
            GAP:   if (tmr_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state == SETUP || state == SHIFT || state == HOLD) begin
            spi_nss  = 1'b0;
            spi_mosi = tx[23];
        end
        unique case (state_nx)
            SETUP:   tmr_load = TW'(CS_SETUP - 1);
            HOLD:    tmr_load = TW'(CS_HOLD - 1);
            GAP:     tmr_load = TW'(IDLE_GAP - 1);
            default: tmr_load = '0;
        endcase
    end

    // Phase timer and bit counter restart on every state entry.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tmr     <= '0;
            bit_cnt <= '0;
        end else if (entering) begin
            tmr     <= tmr_load;
            bit_cnt <= last_bit;
        end else begin
            if (!tmr_done) tmr <= tmr - 1'b1;
            if (fall_tick && bit_cnt != 5'd0) bit_cnt <= bit_cnt - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx       <= '0;
            rx       <= '0;
            last_bit <= '0;
        end else if (accept) begin
            last_bit <= frame_last_bit(cmd_nbytes);
            rx       <= '0;
            unique case (cmd_nbytes)
                2'd0:    tx <= {cmd_opcode, 16'h0000};
                2'd1:    tx <= {cmd_opcode, cmd_data[7:0], 8'h00};
                default: tx <= {cmd_opcode, cmd_data};
            endcase
        end else begin
            if (fall_tick) tx <= {tx[22:0], 1'b0};
            if (rise_tick) rx <= {rx[22:0], spi_miso};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= (state == HOLD) && (state_nx == GAP);
            if ((state == HOLD) && (state_nx == GAP)) rsp_data <= rx;
        end
    end

endmodule

// File: tb/tb_dds_spi_cmd_master.sv
// Directed bench for dds_spi_cmd_master: default-timing instance plus
// a CLK_DIV=1 / CS_SETUP=1 / CS_HOLD=1 instance.
module tb_dds_spi_cmd_master;
    import dds_spi_pkg::*;

    typedef struct {
        logic [23:0] mo;
        logic [23:0] rsp;
        int nrise;
        int low;
        int nvalid;
        int first_rise;
        int last_rise;
        int nss_rise;
        int rdy_at;
    } obs_t;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_opcode = '0;
    logic [15:0] cmd_data = '0;
    logic [1:0]  cmd_nbytes = '0;
    logic        cmd_ready, rsp_valid, busy;
    logic        spi_sclk, spi_mosi, spi_nss, spi_miso;
    logic [23:0] rsp_data;
    logic [23:0] slave_sh = '0;

    logic        q_valid = 1'b0;
    logic [7:0]  q_opcode = '0;
    logic        q_ready, q_rsp_valid, q_busy;
    logic        q_sclk, q_mosi, q_nss;
    logic [23:0] q_rsp_data;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign spi_miso = slave_sh[23];

    dds_spi_cmd_master dut (
        .clk        (clk),
        .nreset     (nreset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_data   (cmd_data),
        .cmd_nbytes (cmd_nbytes),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_nss    (spi_nss),
        .spi_miso   (spi_miso)
    );

    dds_spi_cmd_master #(
        .CLK_DIV  (1),
        .CS_SETUP (1),
        .CS_HOLD  (1),
        .IDLE_GAP (4)
    ) dut_fast (
        .clk        (clk),
        .nreset     (nreset),
        .cmd_valid  (q_valid),
        .cmd_ready  (q_ready),
        .cmd_opcode (q_opcode),
        .cmd_data   (16'h0000),
        .cmd_nbytes (2'd0),
        .rsp_valid  (q_rsp_valid),
        .rsp_data   (q_rsp_data),
        .busy       (q_busy),
        .spi_sclk   (q_sclk),
        .spi_mosi   (q_mosi),
        .spi_nss    (q_nss),
        .spi_miso   (1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at the negedge right after an accept edge; returns at the
    // first negedge where cmd_ready is back high.
    task automatic watch(output obs_t o);
        logic prev;
        int i;
        o = '{default: 0};
        o.first_rise = -1;
        o.nss_rise = -1;
        prev = 1'b0;
        i = 0;
        while (!cmd_ready && i < 1000) begin
            if (!spi_nss) o.low++;
            else if (o.nss_rise < 0 && o.low > 0) o.nss_rise = i;
            if (spi_sclk && !prev) begin
                if (o.nrise == 0) o.first_rise = i;
                o.last_rise = i;
                o.nrise++;
                o.mo = {o.mo[22:0], spi_mosi};
            end
            if (!spi_sclk && prev) slave_sh = slave_sh << 1;
            if (rsp_valid) begin
                o.nvalid++;
                o.rsp = rsp_data;
            end
            prev = spi_sclk;
            i++;
            @(negedge clk);
        end
        o.rdy_at = i;
        chk("frame_done", cmd_ready, 1'b1);
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] d,
                         input logic [1:0] nb, input logic [23:0] sl);
        slave_sh   = sl;
        cmd_opcode = op;
        cmd_data   = d;
        cmd_nbytes = nb;
        cmd_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_opcode = 8'h00;
        cmd_data   = 16'h0000;
        cmd_nbytes = 2'd0;
    endtask

    initial begin
        obs_t o;
        obs_t o2;
        int bsy;
        int nr;
        logic prev;
        int low, first, last, i;
        logic [7:0] qmo;

        repeat (3) @(negedge clk);
        chk("rst_nss", spi_nss, 1'b1);
        chk("rst_sclk", spi_sclk, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 24'h0);
        nreset = 1'b1;
        @(negedge clk);

        issue(CMD_FREQ, 16'h1234, 2'd2, 24'hA55AC3);
        watch(o);
        chk("freq_mosi", o.mo, 24'h011234);
        chk("freq_rises", o.nrise, 24);
        chk("freq_nss_low", o.low, 196);
        chk("freq_rsp_pulses", o.nvalid, 1);
        chk("freq_miso", o.rsp, 24'hA55AC3);
        chk("freq_first_rise", o.first_rise, 6);
        chk("freq_valid_at_nss_rise", o.nss_rise, 196);
        chk("freq_gap", o.rdy_at - o.nss_rise, 4);

        issue(CMD_ENV, 16'h0080, 2'd1, 24'h0);
        watch(o);
        chk("env_mosi", o.mo, 24'h000280);
        chk("env_rises", o.nrise, 16);
        chk("env_nss_low", o.low, 132);

        issue(8'h03, 16'hBEEF, 2'd0, 24'h3C0000);
        watch(o);
        chk("n0_mosi", o.mo, 24'h000003);
        chk("n0_rises", o.nrise, 8);
        chk("n0_nss_low", o.low, 68);
        chk("n0_miso", o.rsp, 24'h00003C);

        cmd_opcode = 8'h11;
        cmd_data   = 16'h0000;
        cmd_nbytes = 2'd0;
        cmd_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_opcode = 8'h22;
        cmd_data   = 16'hABCD;
        cmd_nbytes = 2'd3;
        slave_sh   = 24'h0;
        watch(o);
        chk("b2b_first_mosi", o.mo, 24'h000011);
        chk("b2b_ready_at", o.rdy_at, 72);
        chk("b2b_gap", o.rdy_at - o.nss_rise, 4);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        watch(o2);
        chk("b2b_n3_mosi", o2.mo, 24'h22ABCD);
        chk("b2b_n3_rises", o2.nrise, 24);
        chk("b2b_n3_nss_low", o2.low, 196);

        issue(CMD_ENV, 16'h0055, 2'd1, 24'h0);
        repeat (20) @(negedge clk);
        cmd_opcode = 8'h77;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        watch(o);
        chk("pulse_one_rsp", o.nvalid, 1);
        bsy = 0;
        repeat (10) begin
            if (busy || !spi_nss) bsy++;
            @(negedge clk);
        end
        chk("pulse_dropped", bsy, 0);

        issue(CMD_FREQ, 16'hFFFF, 2'd2, 24'h0);
        nr = 0;
        prev = 1'b0;
        for (int k = 0; k < 500 && nr < 10; k++) begin
            if (spi_sclk && !prev) nr++;
            prev = spi_sclk;
            if (nr < 10) @(negedge clk);
        end
        chk("mid_rises", nr, 10);
        chk("mid_sclk_high", spi_sclk, 1'b1);
        #2 nreset = 1'b0;
        #1;
        chk("mid_rst_nss", spi_nss, 1'b1);
        chk("mid_rst_sclk", spi_sclk, 1'b0);
        chk("mid_rst_mosi", spi_mosi, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        issue(CMD_ENV, 16'h0080, 2'd1, 24'h0);
        watch(o);
        chk("post_rst_mosi", o.mo, 24'h000280);
        chk("post_rst_rises", o.nrise, 16);
        chk("post_rst_nss_low", o.low, 132);

        q_opcode = 8'hFF;
        q_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        q_valid = 1'b0;
        low = 0;
        nr = 0;
        first = -1;
        last = -1;
        qmo = '0;
        prev = 1'b0;
        i = 0;
        while (!q_ready && i < 200) begin
            if (!q_nss) low++;
            if (q_sclk && !prev) begin
                if (nr == 0) first = i;
                last = i;
                nr++;
                qmo = {qmo[6:0], q_mosi};
            end
            prev = q_sclk;
            i++;
            @(negedge clk);
        end
        chk("fast_done", q_ready, 1'b1);
        chk("fast_rises", nr, 8);
        chk("fast_nss_low", low, 18);
        chk("fast_first_rise", first, 2);
        chk("fast_period", last - first, 14);
        chk("fast_mosi", qmo, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
